// File: rtl/barrel_rotate_pipe.sv
// Pipelined WIDTH-bit rotate/shift unit: amount bit k is applied in registered
// stage k, with valid/ready flow control and a single global stall.
module barrel_rotate_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_SHR = 2'b10;
  localparam logic [1:0] MODE_SHL = 2'b11;

  logic advance_s;

  // One power-of-two step; d never exceeds WIDTH/2, so WIDTH-d stays in range.
  function automatic logic [WIDTH-1:0] step_xform(
    input logic [WIDTH-1:0] x,
    input logic [1:0]       mode,
    input int unsigned      d
  );
    logic [WIDTH-1:0] r;
    case (mode)
      MODE_ROR: r = (x >> d) | (x << (WIDTH - d));
      MODE_ROL: r = (x << d) | (x >> (WIDTH - d));
      MODE_SHR: r = x >> d;
      MODE_SHL: r = x << d;
      default:  r = x;
    endcase
    return r;
  endfunction

  genvar k;
  generate
    for (k = 0; k < SHW; k++) begin : g_stage
      // src_amt_s bit 0 is amount bit k; higher bits belong to later stages.
      logic             src_vld_s;
      logic [WIDTH-1:0] src_data_s;
      logic [SHW-k-1:0] src_amt_s;
      logic [1:0]       src_mode_s;
      logic [WIDTH-1:0] xf_data_s;
      logic             vld_r;
      logic [WIDTH-1:0] data_r;
      logic [1:0]       mode_r;

      if (k == 0) begin : g_src_in
        assign src_vld_s  = in_valid;
        assign src_data_s = in_data;
        assign src_amt_s  = in_amt;
        assign src_mode_s = in_mode;
      end else begin : g_src_prev
        assign src_vld_s  = g_stage[k-1].vld_r;
        assign src_data_s = g_stage[k-1].data_r;
        assign src_amt_s  = g_stage[k-1].g_res.res_r;
        assign src_mode_s = g_stage[k-1].mode_r;
      end

      // Apply this stage's 2^k step only when its amount bit is set.
      always_comb begin
        if (src_amt_s[0]) begin
          xf_data_s = step_xform(src_data_s, src_mode_s, 32'd1 << k);
        end else begin
          xf_data_s = src_data_s;
        end
      end

      // Stage register; the whole pipe advances or holds together.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_r  <= 1'b0;
          data_r <= '0;
          mode_r <= 2'b00;
        end else if (advance_s) begin
          vld_r  <= src_vld_s;
          data_r <= xf_data_s;
          mode_r <= src_mode_s;
        end else begin
          vld_r  <= vld_r;
          data_r <= data_r;
          mode_r <= mode_r;
        end
      end

      if (k < SHW - 1) begin : g_res
        logic [SHW-k-2:0] res_r;

        // Carry only the amount bits that later stages still need.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            res_r <= '0;
          end else if (advance_s) begin
            res_r <= src_amt_s[SHW-k-1:1];
          end else begin
            res_r <= res_r;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[SHW-1].vld_r;
  assign out_data  = g_stage[SHW-1].data_r;
  assign out_mode  = g_stage[SHW-1].mode_r;

  // A bubble at the output never blocks the pipe.
  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s;

endmodule

// File: tb/tb_barrel_rotate_pipe.sv
// Scoreboard bench for barrel_rotate_pipe: WIDTH=32 and WIDTH=8 instances,
// directed vectors, streaming, backpressure and mid-stream reset.
module tb_barrel_rotate_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_mode, out_mode;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_amt8;
  logic [1:0]  in_mode8, out_mode8;

  barrel_rotate_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode)
  );

  barrel_rotate_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .in_amt(in_amt8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_mode(out_mode8)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp8_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pol   = 0;   // out_ready policy: 0 always 1, 1 random, 2 always 0
  bit          hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic [1:0]  hold_mode;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref32(input logic [31:0] x, input logic [4:0] a,
                                        input logic [1:0] m);
    logic [63:0] dbl;
    dbl = {x, x};
    case (m)
      2'b00:   begin dbl = dbl >> a; return dbl[31:0];  end
      2'b01:   begin dbl = dbl << a; return dbl[63:32]; end
      2'b10:   return x >> a;
      default: return x << a;
    endcase
  endfunction

  function automatic logic next_rdy();
    if (pol == 0) return 1'b1;
    if (pol == 1) return ($urandom_range(0, 1) == 1);
    return 1'b0;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = next_rdy();
    end
  endtask

  task automatic drive_op(input logic [31:0] d, input logic [4:0] a,
                          input logic [1:0] m, input logic [31:0] e);
    int   tries;
    bit   done;
    exp_t ent;
    tries = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_amt    = a;
      in_mode   = m;
      out_ready = next_rdy();
      #1;
      tries++;
      if (in_ready) begin
        ent.data = e;
        ent.mode = m;
        ent.cyc  = cyc + 5;
        ent.lat  = (pol == 0);
        exp_q.push_back(ent);
        done = 1'b1;
        if (pol == 0) check("stream_in_ready", tries, 1);
      end else if (tries > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
  endtask

  task automatic drain();
    pol = 0;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic drive8(input logic [7:0] d, input logic [2:0] a,
                        input logic [1:0] m, input logic [7:0] e);
    exp_t ent;
    @(negedge clk);
    in_valid8 = 1'b1;
    in_data8  = d;
    in_amt8   = a;
    in_mode8  = m;
    #1;
    check("w8_in_ready", in_ready8, 1'b1);
    ent.data = {24'd0, e};
    ent.mode = m;
    ent.cyc  = cyc + 3;
    ent.lat  = 1'b1;
    exp8_q.push_back(ent);
    @(negedge clk);
    in_valid8 = 1'b0;
    for (int i = 0; i < 20 && exp8_q.size() != 0; i++) @(negedge clk);
    check("w8_drain_empty", exp8_q.size(), 0);
  endtask

  // Monitor for the 32-bit instance: handshake law, stall stability, scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #2;
    check("in_ready_eq", in_ready, !out_valid || out_ready);
    if (hold_pend) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, hold_data);
      check("stall_mode", out_mode, hold_mode);
    end
    hold_pend = out_valid && !out_ready && !rst;
    hold_data = out_data;
    hold_mode = out_mode;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", out_data, 32'hXXXXXXXX);
      end else begin
        e = exp_q.pop_front();
        check("result_data", out_data, e.data);
        check("result_mode", out_mode, e.mode);
        if (e.lat) check("latency", cyc, e.cyc);
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (out_valid8 && out_ready8) begin
      if (exp8_q.size() == 0) begin
        check("w8_unexpected", {24'd0, out_data8}, 32'hXXXXXXXX);
      end else begin
        e = exp8_q.pop_front();
        check("w8_data", {24'd0, out_data8}, e.data);
        check("w8_mode", out_mode8, e.mode);
        check("w8_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  logic [31:0] dir_d [10] = '{32'h80000001, 32'h80000001, 32'hF0000000, 32'h0000000F,
                              32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                              32'h00000001, 32'h00000001};
  logic [4:0]  dir_a [10] = '{5'd1, 5'd4, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31};
  logic [1:0]  dir_m [10] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11,
                              2'b00, 2'b01};
  logic [31:0] dir_e [10] = '{32'hC0000000, 32'h00000018, 32'h0F000000, 32'h80000000,
                              32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                              32'h00000002, 32'h80000000};

  initial begin
    logic [31:0] d;
    logic [4:0]  a;
    logic [1:0]  m;
    in_valid  = 1'b0; in_data  = 32'd0; in_amt  = 5'd0; in_mode  = 2'b00; out_ready  = 1'b1;
    in_valid8 = 1'b0; in_data8 = 8'd0;  in_amt8 = 3'd0; in_mode8 = 2'b00; out_ready8 = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_mode", out_mode, 2'b00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_w8_out_valid", out_valid8, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    pol = 0;
    for (int i = 0; i < 10; i++) begin
      drive_op(dir_d[i], dir_a[i], dir_m[i], dir_e[i]);
      drain();
    end

    pol = 0;
    for (int i = 0; i < 100; i++) begin
      d = $urandom();
      a = 5'($urandom_range(0, 31));
      m = 2'($urandom_range(0, 3));
      drive_op(d, a, m, ref32(d, a, m));
    end
    drain();

    pol = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      d = $urandom();
      a = 5'($urandom_range(0, 31));
      m = 2'($urandom_range(0, 3));
      drive_op(d, a, m, ref32(d, a, m));
    end
    drain();

    pol = 2;
    for (int i = 0; i < 3; i++) drive_op(32'hA5A5_0000 + i, 5'd3, 2'b00, 32'd0);
    idle(4);
    #3;
    check("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_out_mode", out_mode, 2'b00);
    check("mid_rst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    hold_pend = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    pol = 0;
    idle(8);
    drive_op(32'h12345678, 5'd8, 2'b01, 32'h34567812);
    drain();

    drive8(8'h81, 3'd1, 2'b00, 8'hC0);
    drive8(8'hFF, 3'd7, 2'b11, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
